// File: rtl/fsqrt_round_pack.sv
// Final FSQRT stage: latches operand metadata on issue, then normalizes, rounds and packs the root word.
module fsqrt_round_pack #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ena,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [1:0]  rm,
  input  logic [31:0] q,
  input  logic        q_valid,
  output logic [31:0] s,
  output logic        s_valid,
  output logic        busy,
  output logic        inexact,
  output logic        invalid
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned WORD_W = 32;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic [1:0] {CL_NORMAL, CL_ZERO, CL_INF, CL_INVALID} cls_t;

  state_t             state, state_d;
  cls_t               cls_r, cls_d, cls_in_c;
  logic               sign_r, sign_d;
  logic [EXP_W-1:0]   ea_r, ea_d;
  logic [1:0]         rm_r, rm_d;
  logic [WORD_W-1:0]  s_d;
  logic               s_valid_d, busy_d, inexact_d, invalid_d;

  logic [FRAC_W-1:0]  mant_c;
  logic               guard_c, sticky_c, round_up_c;
  logic [FRAC_W:0]    frac_sum_c;
  logic [EXP_W-1:0]   er_c;
  logic [WORD_W-1:0]  res_c;
  logic               res_ix_c, res_iv_c;

  // Classify the incoming operand; denormals flush to signed zero before the sign check.
  always_comb begin
    cls_in_c = CL_NORMAL;
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) cls_in_c = CL_INVALID;
    else if (a[30:23] == 8'h00)                 cls_in_c = CL_ZERO;
    else if (a[31])                             cls_in_c = CL_INVALID;
    else if (a[30:23] == 8'hFF)                 cls_in_c = CL_INF;
  end

  // Normalize the root word, select guard/sticky and apply the rounding mode.
  always_comb begin
    mant_c   = q[31] ? q[30:8] : q[29:7];
    guard_c  = q[31] ? q[7]    : q[6];
    sticky_c = q[31] ? (|q[6:0]) : (|q[5:0]);
    case (rm_r)
      2'd0:    round_up_c = guard_c & (sticky_c | mant_c[0]);
      2'd2:    round_up_c = guard_c | sticky_c;
      default: round_up_c = 1'b0;
    endcase
    frac_sum_c = {1'b0, mant_c} + (FRAC_W+1)'(round_up_c);
    er_c = EXP_W'((10'(ea_r) + 10'd127) >> 1) + EXP_W'(q[31]) + EXP_W'(frac_sum_c[FRAC_W]);
  end

  // Pick the packed result and flags for the latched operand class.
  always_comb begin
    res_c    = '0;
    res_ix_c = 1'b0;
    res_iv_c = 1'b0;
    case (cls_r)
      CL_INVALID: begin
        res_c    = QNAN;
        res_iv_c = 1'b1;
      end
      CL_INF:  res_c = 32'h7F80_0000;
      CL_ZERO: res_c = {sign_r, 31'd0};
      default: begin
        res_c    = {1'b0, er_c, frac_sum_c[FRAC_W-1:0]};
        res_ix_c = guard_c | sticky_c;
      end
    endcase
  end

  // Next-state and next-output logic; everything holds while ena is low.
  always_comb begin
    state_d   = state;
    cls_d     = cls_r;
    sign_d    = sign_r;
    ea_d      = ea_r;
    rm_d      = rm_r;
    s_d       = s;
    s_valid_d = s_valid;
    busy_d    = busy;
    inexact_d = inexact;
    invalid_d = invalid;
    if (ena) begin
      s_valid_d = 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_WAIT;
            cls_d   = cls_in_c;
            sign_d  = a[31];
            ea_d    = a[30:23];
            rm_d    = rm;
            busy_d  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (q_valid) begin
            state_d   = ST_IDLE;
            s_d       = res_c;
            inexact_d = res_ix_c;
            invalid_d = res_iv_c;
            s_valid_d = 1'b1;
            busy_d    = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, metadata and output registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= ST_IDLE;
      cls_r   <= CL_NORMAL;
      sign_r  <= 1'b0;
      ea_r    <= '0;
      rm_r    <= '0;
      s       <= '0;
      s_valid <= 1'b0;
      busy    <= 1'b0;
      inexact <= 1'b0;
      invalid <= 1'b0;
    end else begin
      state   <= state_d;
      cls_r   <= cls_d;
      sign_r  <= sign_d;
      ea_r    <= ea_d;
      rm_r    <= rm_d;
      s       <= s_d;
      s_valid <= s_valid_d;
      busy    <= busy_d;
      inexact <= inexact_d;
      invalid <= invalid_d;
    end
  end

endmodule

// File: tb/tb_fsqrt_round_pack.sv
// Bench for fsqrt_round_pack: directed vector table, corner sequences and a randomized reference model.
module tb_fsqrt_round_pack;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        ena = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [1:0]  rm = '0;
  logic [31:0] q = '0;
  logic        q_valid = 1'b0;
  logic [31:0] s;
  logic        s_valid, busy, inexact, invalid;

  int n_cmp = 0;
  int n_err = 0;

  fsqrt_round_pack dut (
    .clk(clk), .clrn(clrn), .ena(ena), .start(start), .a(a), .rm(rm),
    .q(q), .q_valid(q_valid), .s(s), .s_valid(s_valid), .busy(busy),
    .inexact(inexact), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  rm;
    logic [31:0] q;
    logic [31:0] s;
    logic        ix;
    logic        iv;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: value-level sqrt rounding from the remainder below the kept fraction.
  function automatic void model(input logic [31:0] av, input logic [1:0] rmv, input logic [31:0] qv,
                                output logic [31:0] sv, output logic ix, output logic iv);
    int unsigned e, sh, er;
    longint unsigned rem, half, m, frac;
    bit up;
    e = av[30:23];
    ix = 1'b0;
    iv = 1'b0;
    if (e == 255 && av[22:0] != 0) begin sv = QNAN; iv = 1'b1; end
    else if (e == 0) sv = {av[31], 31'd0};
    else if (av[31]) begin sv = QNAN; iv = 1'b1; end
    else if (e == 255) sv = 32'h7F80_0000;
    else begin
      sh   = qv[31] ? 8 : 7;
      rem  = longint'(qv) % (64'd1 << sh);
      half = 64'd1 << (sh - 1);
      m    = longint'(qv) >> sh;
      frac = m % (64'd1 << 23);
      er   = (e + 127) / 2 + (sh == 8 ? 1 : 0);
      case (rmv)
        2'd0:    up = (rem > half) || (rem == half && frac % 2 == 1);
        2'd2:    up = (rem != 0);
        default: up = 1'b0;
      endcase
      frac = frac + (up ? 1 : 0);
      if (frac == (64'd1 << 23)) begin frac = 0; er++; end
      ix = (rem != 0);
      sv = {1'b0, 8'(er), 23'(frac)};
    end
  endfunction

  // One full operation: issue, wait lat cycles, deliver root, check retirement.
  task automatic run_op(input string name, input logic [31:0] av, input logic [1:0] rmv,
                        input logic [31:0] qv, input int lat,
                        input logic [31:0] es, input logic eix, input logic eiv);
    @(negedge clk);
    a = av; rm = rmv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; rm = 2'($urandom);
    chk({name, ".busy"}, 32'(busy), 32'd1);
    repeat (lat) begin
      q = $urandom;
      @(negedge clk);
    end
    q = qv; q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0; q = $urandom;
    chk({name, ".s_valid"}, 32'(s_valid), 32'd1);
    chk({name, ".s"}, s, es);
    chk({name, ".inexact"}, 32'(inexact), 32'(eix));
    chk({name, ".invalid"}, 32'(invalid), 32'(eiv));
    chk({name, ".busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({name, ".pulse_end"}, 32'(s_valid), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] es, av, qv;
    logic        eix, eiv;
    logic [1:0]  rmv;
    int          lat, guard;

    vecs.push_back('{32'h4080_0000, 2'd0, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F80_0000, 2'd0, 32'h7FFF_FFC0, 32'h4000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h3F80_0000, 2'd1, 32'h7FFF_FFC0, 32'h3FFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{32'hBF80_0000, 2'd0, 32'h4000_0000, QNAN,          1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000, 2'd0, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h7F80_0000, 2'd0, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0001, 2'd0, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0001, 2'd2, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h7FC0_0001, 2'd0, 32'h4000_0000, QNAN,          1'b0, 1'b1});
    vecs.push_back('{32'hFF80_0000, 2'd0, 32'h4000_0000, QNAN,          1'b0, 1'b1});
    vecs.push_back('{32'h3F80_0000, 2'd0, 32'h4000_0040, 32'h3F80_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h3F80_0000, 2'd0, 32'h4000_00C0, 32'h3F80_0002, 1'b1, 1'b0});
    vecs.push_back('{32'h3F80_0000, 2'd2, 32'h4000_0001, 32'h3F80_0001, 1'b1, 1'b0});
    vecs.push_back('{32'h3F80_0000, 2'd3, 32'h4000_0001, 32'h3F80_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h3F80_0000, 2'd0, 32'h8000_0180, 32'h4000_0002, 1'b1, 1'b0});
    vecs.push_back('{32'h3F80_0000, 2'd0, 32'h8000_0081, 32'h4000_0001, 1'b1, 1'b0});
    vecs.push_back('{32'h7F7F_FFFF, 2'd2, 32'h7FFF_FFFF, 32'h5F80_0000, 1'b1, 1'b0});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.s", s, 32'd0);
    chk("rst.s_valid", 32'(s_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.inexact", 32'(inexact), 32'd0);
    chk("rst.invalid", 32'(invalid), 32'd0);
    clrn = 1'b1;

    // q_valid while idle is ignored
    @(negedge clk);
    q = 32'h4000_0000; q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    chk("idle_qv.s_valid", 32'(s_valid), 32'd0);
    chk("idle_qv.busy", 32'(busy), 32'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].rm, vecs[i].q, i % 3,
             vecs[i].s, vecs[i].ix, vecs[i].iv);

    // ena low for 3 cycles while q_valid is offered
    @(negedge clk);
    a = 32'h4080_0000; rm = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ena = 1'b0; q = 32'h4000_0000; q_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ena_low%0d.s_valid", k), 32'(s_valid), 32'd0);
      chk($sformatf("ena_low%0d.busy", k), 32'(busy), 32'd1);
    end
    ena = 1'b1;
    @(negedge clk);
    q_valid = 1'b0; ena = 1'b0;
    chk("ena_rise.s_valid", 32'(s_valid), 32'd1);
    chk("ena_rise.s", s, 32'h4000_0000);
    @(negedge clk);
    chk("ena_hold.s_valid", 32'(s_valid), 32'd1);
    ena = 1'b1;
    @(negedge clk);
    chk("ena_rel.s_valid", 32'(s_valid), 32'd0);

    // Second start in WAIT is ignored
    @(negedge clk);
    a = 32'h4080_0000; rm = 2'd0; start = 1'b1;
    @(negedge clk);
    a = 32'hBF80_0000; rm = 2'd2;
    @(negedge clk);
    start = 1'b0; q = 32'h4000_0001; q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    chk("restart.s", s, 32'h4000_0000);
    chk("restart.invalid", 32'(invalid), 32'd0);
    chk("restart.inexact", 32'(inexact), 32'd1);
    @(negedge clk);
    chk("restart.busy", 32'(busy), 32'd0);
    chk("restart.s_valid", 32'(s_valid), 32'd0);

    // Reset during WAIT abandons the operation
    @(negedge clk);
    a = 32'h3F80_0000; rm = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clrn = 1'b0;
    #1;
    chk("midrst.s", s, 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.inexact", 32'(inexact), 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    q = 32'h4000_0000; q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    chk("midrst.no_valid", 32'(s_valid), 32'd0);
    chk("midrst.s_after", s, 32'd0);

    // Randomized operations against the reference model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       av = {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
        1:       av = {1'($urandom), 8'hFF, 23'd0};
        2:       av = {1'($urandom), 8'h00, 23'd0};
        3:       av = {1'($urandom), 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
        4:       av = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
        default: av = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
      rmv = 2'($urandom);
      qv  = $urandom;
      if (qv[31:30] == 2'b00) qv[30] = 1'b1;
      if ($urandom_range(0, 3) == 0) qv[5:0] = 6'd0;
      lat = $urandom_range(0, 3);
      model(av, rmv, qv, es, eix, eiv);
      run_op($sformatf("rnd%0d", n), av, rmv, qv, lat, es, eix, eiv);
    end

    guard = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the bench never hangs
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
